// File: rtl/keypad_entry_ctrl.sv
// Microwave keypad entry: debounces the highest-priority digit key and shifts
// each accepted digit into a 3-digit M:SS cook-time register.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keys,
  input  logic       enable,
  input  logic       clear,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] digit_code,
  output logic       loadn,
  output logic [1:0] digit_count,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, WAIT_RELEASE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    cand;
  logic [3:0]    code;
  logic          has_key;

  // Ascending scan so the highest set bit wins.
  always_comb begin
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keys[i]) code = 4'(i);
    end
    has_key = |keys;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= 4'd0;
      min_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      sec_ones    <= 4'd0;
      digit_code  <= 4'd0;
      digit_count <= 2'd0;
      loadn       <= 1'b1;
      busy        <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      cnt         <= '0;
      min_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      sec_ones    <= 4'd0;
      digit_code  <= 4'd0;
      digit_count <= 2'd0;
      loadn       <= 1'b1;
      busy        <= 1'b0;
    end else begin
      loadn <= 1'b1;
      case (state)
        IDLE: begin
          if (enable && has_key) begin
            cand  <= code;
            cnt   <= '0;
            state <= DEBOUNCE;
            busy  <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!enable || !has_key || code != cand) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            // loadn is registered, so it drops on entry to ACCEPT.
            state <= ACCEPT;
            loadn <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACCEPT: begin
          min_ones   <= sec_tens;
          sec_tens   <= sec_ones;
          sec_ones   <= cand;
          digit_code <= cand;
          if (digit_count != 2'd3) digit_count <= digit_count + 2'd1;
          cnt   <= '0;
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (has_key) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with DEBOUNCE_CYCLES=4; inputs change and
// outputs are sampled on the falling clock edge.
module tb_keypad_entry_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] keys;
  logic       enable;
  logic       clear;
  logic [3:0] min_ones, sec_tens, sec_ones, digit_code;
  logic       loadn, busy;
  logic [1:0] digit_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .keys(keys), .enable(enable), .clear(clear),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .digit_code(digit_code), .loadn(loadn), .digit_count(digit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (loadn === 1'b0) pulses++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int d, input int hold, input int rel);
    keys = 10'(1 << d);
    tick(hold);
    keys = 10'd0;
    tick(rel);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; keys = 10'd0; enable = 1'b0; clear = 1'b0;
    tick(2);
    checks++; if ({min_ones, sec_tens, sec_ones} !== 12'h000) begin errors++; $display("FAIL reset_digits: got %h want 000", {min_ones, sec_tens, sec_ones}); end
    checks++; if (digit_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", digit_code); end
    checks++; if ({loadn, busy, digit_count} !== 4'b1000) begin errors++; $display("FAIL reset_ctrl: got loadn=%b busy=%b cnt=%0d want 1 0 0", loadn, busy, digit_count); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_single_digit();
    enable = 1'b1;
    pulses = 0;
    press(5, 8, 6);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL t1_pulses: got %0d want 1", pulses); end
    checks++; if ({min_ones, sec_tens, sec_ones} !== 12'h005) begin errors++; $display("FAIL t1_digits: got %h want 005", {min_ones, sec_tens, sec_ones}); end
    checks++; if (digit_count !== 2'd1) begin errors++; $display("FAIL t1_count: got %0d want 1", digit_count); end
    checks++; if (digit_code !== 4'd5) begin errors++; $display("FAIL t1_code: got %0d want 5", digit_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy: got %b want 0", busy); end
  endtask

  task automatic test_latency();
    do_clear();
    pulses = 0;
    keys = 10'(1 << 3);
    tick(4);
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL lat_early: got loadn=%b want 1", loadn); end
    tick(1);
    checks++; if (loadn !== 1'b0) begin errors++; $display("FAIL lat_low: got loadn=%b want 0", loadn); end
    checks++; if (sec_ones !== 4'd0) begin errors++; $display("FAIL lat_preshift: got %0d want 0", sec_ones); end
    tick(1);
    checks++; if (loadn !== 1'b1 || sec_ones !== 4'd3) begin errors++; $display("FAIL lat_after: got loadn=%b sec_ones=%0d want 1 3", loadn, sec_ones); end
    keys = 10'd0;
    tick(6);
  endtask

  task automatic test_sequence();
    do_clear();
    pulses = 0;
    for (int d = 1; d <= 4; d++) press(d, 8, 6);
    checks++; if ({min_ones, sec_tens, sec_ones} !== 12'h234) begin errors++; $display("FAIL t2_digits: got %h want 234", {min_ones, sec_tens, sec_ones}); end
    checks++; if (digit_count !== 2'd3) begin errors++; $display("FAIL t2_count: got %0d want 3", digit_count); end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL t2_pulses: got %0d want 4", pulses); end
  endtask

  task automatic test_priority_glitch();
    do_clear();
    pulses = 0;
    keys = 10'h201;
    tick(8);
    keys = 10'd0;
    tick(6);
    checks++; if (digit_code !== 4'd9 || sec_ones !== 4'd9) begin errors++; $display("FAIL t3_prio: got code=%0d sec_ones=%0d want 9 9", digit_code, sec_ones); end
    press(7, 3, 6);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL t3_glitch_pulses: got %0d want 1", pulses); end
    checks++; if ({min_ones, sec_tens, sec_ones} !== 12'h009 || digit_code !== 4'd9) begin errors++; $display("FAIL t3_glitch_digits: got %h code=%0d want 009 9", {min_ones, sec_tens, sec_ones}, digit_code); end
    // a second key arriving mid-debounce aborts that press
    keys = 10'(1 << 2); tick(2);
    keys = 10'(1 << 2) | 10'(1 << 6); tick(1);
    keys = 10'd0; tick(6);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL t3_twokey: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_hold();
    do_clear();
    pulses = 0;
    press(4, 40, 2);
    press(4, 8, 6);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL t4_pulses: got %0d want 1", pulses); end
    checks++; if ({min_ones, sec_tens, sec_ones} !== 12'h004 || digit_count !== 2'd1) begin errors++; $display("FAIL t4_digits: got %h cnt=%0d want 004 1", {min_ones, sec_tens, sec_ones}, digit_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy: got %b want 0", busy); end
  endtask

  task automatic test_clear_accept();
    do_clear();
    press(7, 8, 6);
    pulses = 0;
    keys = 10'(1 << 6);
    tick(4);
    clear = 1'b1;
    tick(1);
    keys = 10'd0;
    tick(1);
    clear = 1'b0;
    tick(2);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL t5_pulses: got %0d want 0", pulses); end
    checks++; if ({min_ones, sec_tens, sec_ones} !== 12'h000 || digit_code !== 4'd0 || digit_count !== 2'd0) begin errors++; $display("FAIL t5_digits: got %h code=%0d cnt=%0d want 000 0 0", {min_ones, sec_tens, sec_ones}, digit_code, digit_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b want 0", busy); end
    // clear while already in ACCEPT: the shift is suppressed
    press(7, 8, 6);
    keys = 10'(1 << 6);
    tick(5);
    checks++; if (loadn !== 1'b0) begin errors++; $display("FAIL t5_in_accept: got loadn=%b want 0", loadn); end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    keys = 10'd0;
    checks++; if ({min_ones, sec_tens, sec_ones} !== 12'h000 || digit_count !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL t5_noshift: got %h cnt=%0d busy=%b want 000 0 0", {min_ones, sec_tens, sec_ones}, digit_count, busy); end
    tick(6);
  endtask

  task automatic test_enable_reset();
    do_clear();
    pulses = 0;
    enable = 1'b0;
    keys = 10'(1 << 8);
    tick(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_dis_busy: got %b want 0", busy); end
    tick(5);
    keys = 10'd0;
    tick(6);
    checks++; if (pulses !== 0 || digit_count !== 2'd0) begin errors++; $display("FAIL t6_disabled: got pulses=%0d cnt=%0d want 0 0", pulses, digit_count); end
    enable = 1'b1;
    press(3, 8, 6);
    keys = 10'(1 << 8);
    tick(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_mid_busy: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    checks++; if ({min_ones, sec_tens, sec_ones} !== 12'h000 || digit_code !== 4'd0 || digit_count !== 2'd0) begin errors++; $display("FAIL t6_rst_digits: got %h code=%0d cnt=%0d want 000 0 0", {min_ones, sec_tens, sec_ones}, digit_code, digit_count); end
    checks++; if (loadn !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t6_rst_ctrl: got loadn=%b busy=%b want 1 0", loadn, busy); end
    tick(1);
    reset = 1'b0;
    keys = 10'd0;
    tick(8);
    checks++; if (pulses !== 1 || sec_ones !== 4'd0) begin errors++; $display("FAIL t6_discard: got pulses=%0d sec_ones=%0d want 1 0", pulses, sec_ones); end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_latency();
    test_sequence();
    test_priority_glitch();
    test_hold();
    test_clear_accept();
    test_enable_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
